replay_ctrl: RTL

Transmit-side retry sequencer placed between the transaction-layer word source and the link output. It assigns a 12-bit sequence number to every accepted 16-bit word and holds each word in circular retry storage until it is acknowledged. It retransmits on NAK or on replay-timer expiry, and requests link retraining after repeated replays.

---
 rtl/replay_pkg.sv | 19 +
 rtl/replay_timer.sv | 29 ++
 rtl/replay_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/replay_pkg.sv
// replay_pkg: shared sequence-number width, FSM state type and
// modular sequence arithmetic for the transmit retry sequencer.
package replay_pkg;

  localparam int SEQ_W = 12;

  typedef logic [SEQ_W-1:0] seq_t;

  typedef enum logic {
    NORMAL = 1'b0,
    REPLAY = 1'b1
  } state_t;

  // a - b modulo 2^SEQ_W
  function automatic seq_t seq_diff(seq_t a, seq_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/replay_timer.sv
// replay_timer: replay timeout counter.
// Ports: clk, rst, clr (zero count), en (count), expire (last count).
module replay_timer #(
  parameter int TIMER_W = 10,
  parameter int TIMEOUT = 700
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TIMER_W-1:0] count;

  assign expire = en && (count == TIMER_W'(TIMEOUT - 1));

  // Holds at zero whenever it is not enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/replay_ctrl.sv
// replay_ctrl: transmit retry sequencer with circular retry storage.
// Ports: in_* source side, out_* link side, ack_* ACK/NAK reports,
// replay_active/retrain_req/err_seq status, occupancy (unacked words).
module replay_ctrl
  import replay_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int DEPTH_LOG2     = 6,
  parameter int TIMER_W        = 10,
  parameter int REPLAY_TIMEOUT = 700,
  parameter int REPLAY_MAX     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEQ_W-1:0]  out_seq,
  input  logic              out_ready,
  input  logic              ack_valid,
  input  logic              ack_nak,
  input  logic [SEQ_W-1:0]  ack_seq,
  output logic              replay_active,
  output logic              retrain_req,
  output logic              err_seq,
  output logic [DEPTH_LOG2:0] occupancy
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int RN_W  = $clog2(REPLAY_MAX + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  seq_t next_seq, ackd_seq, tx_ptr, hi_ptr;
  seq_t tx_nxt, hi_nxt, ackd_nxt;
  seq_t occ_full, d, span;
  logic [RN_W-1:0] replay_num, rn_nxt, base;

  state_t state, state_nxt;

  logic full, accept, tx_fire;
  logic ack_ok, legal, is_ack, is_nak, covers;
  logic tmr_en, tmr_clr, tmr_expire, tmo;
  logic start, rollover;

  assign occ_full  = seq_diff(next_seq, ackd_seq) - SEQ_W'(1);
  assign occupancy = occ_full[DEPTH_LOG2:0];
  // occupancy never exceeds DEPTH, so its top bit alone means full
  assign full      = occupancy[DEPTH_LOG2];
  assign in_ready  = !rst && !full;
  assign accept    = in_valid && in_ready;

  assign out_valid = (tx_ptr != next_seq);
  assign out_data  = mem[tx_ptr[DEPTH_LOG2-1:0]];
  assign out_seq   = tx_ptr;
  assign tx_fire   = out_valid && out_ready;

  // d: distance of the report past the last ack
  // span: number of sent-but-unacked words
  assign d      = seq_diff(ack_seq, ackd_seq);
  assign span   = seq_diff(hi_ptr, ackd_seq) - SEQ_W'(1);
  assign ack_ok = ack_nak ? (d <= span)
                          : ((d != '0) && (d <= span));
  assign legal  = ack_valid && ack_ok;
  assign is_ack = legal && !ack_nak;
  assign is_nak = legal && ack_nak;
  assign covers = (d >= seq_diff(tx_ptr, ackd_seq));

  assign tmr_en  = (state == NORMAL)
                && (hi_ptr != ackd_seq + SEQ_W'(1));
  assign tmo     = tmr_expire && !legal;
  assign start   = is_nak || tmo;
  assign tmr_clr = is_ack || start;

  replay_timer #(
    .TIMER_W(TIMER_W),
    .TIMEOUT(REPLAY_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  // A NAK that advances the ack point counts as fresh progress.
  assign base     = (is_nak && (d != '0)) ? '0 : replay_num;
  assign rollover = start && (base == RN_W'(REPLAY_MAX));
  assign ackd_nxt = legal ? ack_seq : ackd_seq;

  always_comb begin
    rn_nxt = replay_num;
    if (is_ack) begin
      rn_nxt = '0;
    end else if (start) begin
      rn_nxt = rollover ? '0 : base + RN_W'(1);
    end
  end

  always_comb begin
    hi_nxt = hi_ptr;
    if ((state == NORMAL) && tx_fire) begin
      hi_nxt = tx_ptr + SEQ_W'(1);
    end
  end

  always_comb begin
    tx_nxt = tx_ptr;
    if (start) begin
      tx_nxt = ackd_nxt + SEQ_W'(1);
    end else if (is_ack && covers) begin
      tx_nxt = ack_seq + SEQ_W'(1);
    end else if (tx_fire) begin
      tx_nxt = tx_ptr + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[next_seq[DEPTH_LOG2-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_seq    <= '0;
      ackd_seq    <= '1;
      tx_ptr      <= '0;
      hi_ptr      <= '0;
      replay_num  <= '0;
      retrain_req <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      if (accept) begin
        next_seq <= next_seq + SEQ_W'(1);
      end
      ackd_seq    <= ackd_nxt;
      tx_ptr      <= tx_nxt;
      hi_ptr      <= hi_nxt;
      replay_num  <= rn_nxt;
      retrain_req <= rollover;
      err_seq     <= ack_valid && !ack_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Replay ends once the resend pointer catches up with hi_ptr.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (hi_nxt == tx_nxt) ? NORMAL : REPLAY;
    end else if ((state == REPLAY) && (tx_nxt == hi_nxt)) begin
      state_nxt = NORMAL;
    end
  end

  always_comb begin
    replay_active = (state == REPLAY);
  end

endmodule
